// File: rtl/bcd_conv_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : bcd_conv_arbiter_if
// Brief  : Requester-side bus of the shared binary-to-BCD converter.
// Rev    : 1.0
// ============================================================================
interface bcd_conv_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int BIN_W = 14
);
    logic [NREQ-1:0]       req;
    logic [NREQ*BIN_W-1:0] bin_flat;
    logic [NREQ-1:0]       ack;
    logic [15:0]           bcd_out;
    logic                  ovf;
    logic [2:0]            grant_id;
    logic                  busy;

    modport master (
        output req, bin_flat,
        input  ack, bcd_out, ovf, grant_id, busy
    );

    modport slave (
        input  req, bin_flat,
        output ack, bcd_out, ovf, grant_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/bcd_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module : bcd_conv_arbiter
// Brief  : Round-robin shared serial shift-and-add-3 binary-to-BCD engine.
// Rev    : 1.0
// ============================================================================
module bcd_conv_arbiter #(
    parameter int NREQ  = 4,
    parameter int BIN_W = 14
) (
    input  wire logic         clk,
    input  wire logic         rst,
    bcd_conv_arbiter_if.slave bif
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       ptr_q,   ptr_d;
    logic [2:0]       grant_q, grant_d;
    logic [BIN_W-1:0] bin_q,   bin_d;
    logic [15:0]      acc_q,   acc_d;
    logic [3:0]       cnt_q,   cnt_d;
    logic             sat_q,   sat_d;
    logic [NREQ-1:0]  ack_q,   ack_d;
    logic [15:0]      bcd_q,   bcd_d;
    logic             ovf_q,   ovf_d;
    logic             busy_q,  busy_d;

    logic [7:0]       w_req_ext;
    logic             w_found;
    logic [2:0]       w_pick;
    logic [BIN_W-1:0] w_sel;
    logic [15:0]      w_adj;
    logic [15:0]      w_next_acc;

    function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return 3'(s);
    endfunction

    // First pending requester at or above the pointer, wrapping around.
    always_comb begin
        w_req_ext            = '0;
        w_req_ext[NREQ-1:0]  = bif.req;
        w_found              = 1'b0;
        w_pick               = ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && w_req_ext[wrap_idx(ptr_q, i)]) begin
                w_found = 1'b1;
                w_pick  = wrap_idx(ptr_q, i);
            end
        end
        w_sel = bif.bin_flat[int'(w_pick)*BIN_W +: BIN_W];
    end

    always_comb begin
        w_adj = '0;
        for (int d = 0; d < 4; d++) begin
            w_adj[4*d +: 4] = (acc_q[4*d +: 4] >= 4'd5) ? acc_q[4*d +: 4] + 4'd3
                                                         : acc_q[4*d +: 4];
        end
        w_next_acc = {w_adj[14:0], bin_q[BIN_W-1]};
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        ack_d   = '0;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (w_found) begin
                    grant_d = w_pick;
                    bin_d   = w_sel;
                    acc_d   = '0;
                    cnt_d   = 4'(BIN_W);
                    sat_d   = 32'(w_sel) > 32'd9999;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bin_d = bin_q << 1;
                // Saturating values keep the accumulator idle so no digit goes past 9.
                acc_d = sat_q ? acc_q : w_next_acc;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    bcd_d   = sat_q ? 16'h9999 : w_next_acc;
                    ovf_d   = sat_q;
                    for (int i = 0; i < NREQ; i++) begin
                        ack_d[i] = (grant_q == 3'(i));
                    end
                end
            end
            DONE: begin
                ptr_d   = wrap_idx(grant_q, 1);
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            ack_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            ack_q   <= ack_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
        end
    end

    assign bif.ack      = ack_q;
    assign bif.bcd_out  = bcd_q;
    assign bif.ovf      = ovf_q;
    assign bif.grant_id = grant_q;
    assign bif.busy     = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_bcd_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_bcd_conv_arbiter
// Brief  : Self-checking bench for the shared BCD converter arbiter.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_bcd_conv_arbiter;
    localparam int NREQ  = 4;
    localparam int BIN_W = 14;
    localparam int LAT   = BIN_W + 1;
    localparam int LIMIT = 60;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_conv_arbiter_if #(.NREQ(NREQ), .BIN_W(BIN_W)) bif ();
    bcd_conv_arbiter #(.NREQ(NREQ), .BIN_W(BIN_W)) dut (.clk(clk), .rst(rst), .bif(bif));

    int n_checks = 0;
    int n_fail   = 0;
    int tb_ptr   = 0;
    int vals [NREQ];

    function automatic logic [15:0] ref_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] pend);
        for (int i = 0; i < NREQ; i++) begin
            if (pend[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < LIMIT && bif.busy; k++) tick();
        chk("wait_idle", 32'(bif.busy), 32'd0);
    endtask

    task automatic wait_ack(output int lat, output int busy_cnt);
        lat      = -1;
        busy_cnt = 0;
        for (int k = 1; k <= LIMIT; k++) begin
            tick();
            if (bif.busy) busy_cnt++;
            if (bif.ack != '0) begin
                lat = k;
                return;
            end
        end
    endtask

    task automatic run_one(input int idx, input int v, input int change_at,
                           input int v2, input bit drop);
        int lat, bc;
        wait_idle();
        bif.bin_flat[idx*BIN_W +: BIN_W] = BIN_W'(v);
        bif.req = NREQ'(1) << idx;
        lat = -1;
        bc  = 0;
        for (int k = 1; k <= LIMIT; k++) begin
            tick();
            if (bif.busy) bc++;
            if (k == change_at) begin
                bif.bin_flat[idx*BIN_W +: BIN_W] = BIN_W'(v2);
                if (drop) bif.req = '0;
            end
            if (bif.ack != '0) begin
                lat = k;
                break;
            end
        end
        chk($sformatf("lat_r%0d_v%0d", idx, v), lat, LAT);
        chk($sformatf("busy_r%0d_v%0d", idx, v), bc, LAT);
        chk($sformatf("ack_r%0d_v%0d", idx, v), 32'(bif.ack), 32'(NREQ'(1) << idx));
        chk($sformatf("gid_r%0d_v%0d", idx, v), 32'(bif.grant_id), idx);
        chk($sformatf("bcd_r%0d_v%0d", idx, v), 32'(bif.bcd_out), 32'(ref_bcd(v)));
        chk($sformatf("ovf_r%0d_v%0d", idx, v), 32'(bif.ovf), 32'(v > 9999));
        bif.req = '0;
        tb_ptr  = (idx + 1) % NREQ;
        tick();
        chk($sformatf("hold_ack_v%0d", v), 32'(bif.ack), 32'd0);
        chk($sformatf("hold_bcd_v%0d", v), 32'(bif.bcd_out), 32'(ref_bcd(v)));
    endtask

    task automatic burst(input string name, input logic [NREQ-1:0] mask,
                         input bit hold, input int nacks);
        logic [NREQ-1:0] pend;
        int lat, bc, exp_i;
        wait_idle();
        for (int i = 0; i < NREQ; i++) bif.bin_flat[i*BIN_W +: BIN_W] = BIN_W'(vals[i]);
        pend    = mask;
        bif.req = mask;
        for (int n = 0; n < nacks; n++) begin
            exp_i = rr_pick(tb_ptr, pend);
            wait_ack(lat, bc);
            chk($sformatf("%s%0d_lat", name, n), lat, (n == 0) ? LAT : BIN_W + 2);
            chk($sformatf("%s%0d_ack", name, n), 32'(bif.ack), 32'(NREQ'(1) << exp_i));
            chk($sformatf("%s%0d_gid", name, n), 32'(bif.grant_id), exp_i);
            chk($sformatf("%s%0d_bcd", name, n), 32'(bif.bcd_out), 32'(ref_bcd(vals[exp_i])));
            chk($sformatf("%s%0d_ovf", name, n), 32'(bif.ovf), 32'(vals[exp_i] > 9999));
            tb_ptr = (exp_i + 1) % NREQ;
            if (!hold) begin
                pend[exp_i] = 1'b0;
                bif.req     = pend;
            end
        end
        bif.req = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks_seen;
        logic [NREQ-1:0] m;
        rst          = 1'b1;
        bif.req      = '0;
        bif.bin_flat = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ack",  32'(bif.ack), 32'd0);
        chk("rst_bcd",  32'(bif.bcd_out), 32'd0);
        chk("rst_ovf",  32'(bif.ovf), 32'd0);
        chk("rst_gid",  32'(bif.grant_id), 32'd0);
        chk("rst_busy", 32'(bif.busy), 32'd0);

        // Directed values, including the saturation boundary.
        run_one(0, 1234, 0, 0, 0);
        run_one(1, 0, 0, 0, 0);
        run_one(2, 9, 0, 0, 0);
        run_one(3, 10, 0, 0, 0);
        run_one(0, 9999, 0, 0, 0);
        run_one(1, 10000, 0, 0, 0);
        run_one(2, 16383, 0, 0, 0);

        // Random single conversions.
        for (int n = 0; n < 8; n++) begin
            run_one(int'($urandom_range(0, NREQ - 1)), int'($urandom_range(0, 16383)), 0, 0, 0);
        end

        // All requesters held continuously from reset.
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        tb_ptr = 0;
        for (int i = 0; i < NREQ; i++) vals[i] = 1000 * (i + 1) + int'($urandom_range(0, 999));
        vals[NREQ-1] = 10000 + int'($urandom_range(0, 6383));
        burst("hold", '1, 1'b1, NREQ + 1);

        // Random multi-request bursts, each requester dropped after its ack.
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < NREQ; i++) vals[i] = int'($urandom_range(0, 16383));
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            burst($sformatf("rb%0d_", b), m, 1'b0, $countones(m));
        end

        // Reset in the middle of a conversion.
        run_one(2, 777, 0, 0, 0);
        wait_idle();
        bif.bin_flat[2*BIN_W +: BIN_W] = BIN_W'(5555);
        bif.req = NREQ'(4);
        tick();
        for (int k = 0; k < 6; k++) tick();
        chk("mid_busy", 32'(bif.busy), 32'd1);
        chk("mid_gid",  32'(bif.grant_id), 32'd2);
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        bif.req = '0;
        tb_ptr  = 0;
        chk("abort_ack",  32'(bif.ack), 32'd0);
        chk("abort_bcd",  32'(bif.bcd_out), 32'd0);
        chk("abort_ovf",  32'(bif.ovf), 32'd0);
        chk("abort_gid",  32'(bif.grant_id), 32'd0);
        chk("abort_busy", 32'(bif.busy), 32'd0);
        acks_seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bif.ack != '0) acks_seen++;
        end
        chk("abort_no_ack", acks_seen, 0);
        vals[1] = 4242;
        vals[3] = 3131;
        burst("post_rst", NREQ'(4'b1010), 1'b0, 2);

        // Input changes and req drop during SHIFT do not disturb the result.
        run_one(0, 4321, 3, 1111, 1);
        chk("chg_bcd_literal", 32'(bif.bcd_out), 32'h4321);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
